lif_neuron_array: RTL and testbench
===================================

// Module: lif_neuron_array
// PURPOSE
//  Time-multiplexed array of NUM_NEURONS leaky integrate-and-fire neurons sharing one datapath.
//  Weighted input events are integrated into per-neuron signed membrane state.
//  A timestep tick launches a sweep that leaks every neuron, fires those at or above threshold,
//  and emits spike events on a valid/ready stream.
//  Successor to the single-neuron LIF core; sits between the synapse event router and the spike arbiter.
// PARAMETERS
//  DATA_WIDTH        16   membrane/weight width, signed two's complement
//  NUM_NEURONS       64   neurons held in state array, >=2
//  IDX_W             $clog2(NUM_NEURONS)  neuron index width
//  RESET_VAL         0    potential after reset and after firing (signed)
//  V_MIN             0    leak floor (signed); potential never leaks below it
//  REFRACTORY_PERIOD 2    timesteps of refractoriness (REFRACTORY_EN only), 1..2^REF_W-1
//  REF_W             4    refractory counter width
// PORTS
//  clk          in   1           clock, all logic on rising edge
//  rst_n        in   1           asynchronous, active-low reset
//  ev_valid     in   1           input event valid
//  ev_ready     out  1           input event accepted when valid&ready
//  ev_idx       in   IDX_W       target neuron
//  ev_weight    in   DATA_WIDTH  signed weight added to target potential
//  tick         in   1           one-cycle timestep pulse
//  cfg_thresh   in   DATA_WIDTH  signed fire threshold, sampled at sweep start
//  cfg_leak     in   DATA_WIDTH  unsigned leak per timestep, sampled at sweep start
//  spk_valid    out  1           output spike valid
//  spk_ready    in   1           downstream accepts spike
//  spk_idx      out  IDX_W       index of firing neuron
//  sweep_busy   out  1           high during SWEEP/STALL
//  tick_overrun out  1           one-cycle pulse: tick dropped (one already pending)
//  rd_idx       in   IDX_W       debug potential read address
//  rd_data      out  DATA_WIDTH  v[rd_idx], registered, 1-cycle latency
// BEHAVIOUR
//  Reset: every v[i] = RESET_VAL, FSM = IDLE, all outputs and the pending flag 0.
//    Reset mid-sweep aborts the sweep; pending spikes are lost.
//  FSM: IDLE -> SWEEP on tick or pending flag. SWEEP -> STALL when spike unaccepted.
//    STALL -> SWEEP on spk_ready. SWEEP -> IDLE after neuron NUM_NEURONS-1 is processed.
//  IDLE: ev_ready=1.
//    Accepted event: v[idx] <= sat(v[idx] + weight), clamped to signed max/min of DATA_WIDTH.
//    Visible on rd_data 2 cycles after acceptance when rd_idx matches.
//    Same-cycle tick and event: the event is integrated; SWEEP begins next cycle.
//  SWEEP: ev_ready=0; one neuron per cycle, index 0..N-1, starting the cycle after the tick.
//    Leak step: l = max(v - cfg_leak, V_MIN), computed in DATA_WIDTH+1 bits.
//    Fire: if l >= cfg_thresh (signed compare), v <= RESET_VAL and a spike for index i is
//      presented next cycle (spk_valid=1, spk_idx=i). Otherwise v <= l.
//    Spike stream holds spk_valid/spk_idx stable until spk_ready. While a spike is unaccepted
//      and the next neuron would also fire, the FSM enters STALL and does not advance.
//    Zero-stall sweep: N cycles; last spike leaves at most 1 cycle after the sweep ends.
//  tick during SWEEP/STALL sets pending (one deep); a further tick while pending pulses tick_overrun.
//  The sweep exits to IDLE only when no spike is outstanding.
//  ev_idx >= NUM_NEURONS: accepted and discarded.
// CONFIGURATION
//  Macro LIF_REFRACTORY_EN.
//  Defined: per-neuron REF_W-bit counter r[i], reset 0.
//    On fire, r[i] <= REFRACTORY_PERIOD.
//    In a sweep, a neuron with r[i]>0 decrements r[i]; no leak, no fire.
//    Events to a neuron with r[i]>0 are accepted and discarded.
//  Undefined: no counters; a neuron may fire on consecutive timesteps.
// STRUCTURE
//  lif_pkg: fsm_state_t enum (IDLE, SWEEP, STALL).
//    Functions sat_add(a,b) and leak_floor(v,leak,vmin).
//  Sub-module lif_update_unit: combinational leak/compare/reset datapath for one neuron per cycle.
//  The state array is a register array; it may map to a 1R1W memory.
// TESTING
//  1. Reset, read all rd_idx -> rd_data = 0; spk_valid = 0, ev_ready = 1.
//  2. Events idx3 +60, +50, thresh=100, leak=1, tick -> one spike idx3 on sweep cycle 4; v[3] = 0.
//  3. idx5 +30, leak=10, 4 ticks -> v[5] = 20, 10, 0, 0 (floored); no spikes.
//  4. idx0,1,2 each +200, spk_ready=0 for 5 cycles, tick -> STALL; spikes 0,1,2 emitted in order,
//     then sweep completes.
//  5. idx7 weight 0x7FF0 then +0x0100 -> v[7] = 0x7FFF (saturated); negative weights clamp at 0x8000.
//  6. Two ticks during a sweep -> one extra sweep runs; tick_overrun pulses once.
//  7. LIF_REFRACTORY_EN: neuron fires, +500 on the next 2 timesteps ignored; fires again on the 3rd.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared types and arithmetic helpers for the LIF neuron array.
//   fsm_state_t : sweep controller states (IDLE, SWEEP, STALL)
//   sat_add     : signed add clamped to the signed range of a w-bit word
//   leak_floor  : max(v - leak, vmin), evaluated one bit wider than the operands
// Helpers work on a 32-bit signed container, so DATA_WIDTH must stay <= 31.
package lif_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    STALL = 2'd2
  } fsm_state_t;

  localparam int unsigned LIF_W = 32;

  typedef logic signed [LIF_W-1:0] lif_word_t;
  typedef logic signed [LIF_W:0]   lif_wide_t;

  function automatic lif_word_t sat_add(input lif_word_t a, input lif_word_t b,
                                        input int unsigned w);
    lif_wide_t s;
    lif_wide_t hi;
    lif_wide_t lo;
    lif_wide_t one;
    one = lif_wide_t'(1);
    s   = lif_wide_t'(a) + lif_wide_t'(b);
    hi  = (one <<< (w - 1)) - one;
    lo  = -(one <<< (w - 1));
    if (s > hi) begin
      s = hi;
    end else if (s < lo) begin
      s = lo;
    end
    return lif_word_t'(s);
  endfunction

  // leak is expected zero-extended (unsigned leak amount).
  function automatic lif_word_t leak_floor(input lif_word_t v, input lif_word_t leak,
                                           input lif_word_t vmin);
    lif_wide_t l;
    l = lif_wide_t'(v) - lif_wide_t'(leak);
    if (l < lif_wide_t'(vmin)) begin
      l = lif_wide_t'(vmin);
    end
    return lif_word_t'(l);
  endfunction

endpackage

// File: rtl/lif_update_unit.sv
// Combinational per-neuron update: leak with floor, threshold compare, reset on fire.
// Ports:
//   v_i      : current membrane potential (signed)
//   thresh_i : fire threshold (signed)
//   leak_i   : leak amount (unsigned)
//   fire_o   : leaked potential reached threshold
//   v_next_o : RESET_VAL when firing, otherwise the leaked potential
module lif_update_unit
  import lif_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int          RESET_VAL  = 0,
  parameter int          V_MIN      = 0
) (
  input  logic signed [DATA_WIDTH-1:0] v_i,
  input  logic signed [DATA_WIDTH-1:0] thresh_i,
  input  logic        [DATA_WIDTH-1:0] leak_i,
  output logic                         fire_o,
  output logic signed [DATA_WIDTH-1:0] v_next_o
);

  lif_word_t leaked;

  always_comb begin
    leaked   = leak_floor(lif_word_t'(v_i), lif_word_t'(leak_i), lif_word_t'(V_MIN));
    fire_o   = (leaked >= lif_word_t'(thresh_i));
    v_next_o = fire_o ? DATA_WIDTH'(RESET_VAL) : leaked[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/lif_neuron_array.sv
// Time-multiplexed array of leaky integrate-and-fire neurons on one shared datapath.
// Events integrate into per-neuron potentials while idle; a tick starts a sweep that
// leaks/fires one neuron per cycle and streams spike indices out on valid/ready.
// Optional feature macro: LIF_REFRACTORY_EN (per-neuron refractory counters).
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   ev_valid/ev_ready          : input event handshake (ready only while idle)
//   ev_idx, ev_weight          : target neuron and signed weight
//   tick                       : timestep pulse
//   cfg_thresh, cfg_leak       : threshold / leak, captured when a sweep starts
//   spk_valid/spk_ready/spk_idx: output spike stream
//   sweep_busy                 : sweep in progress
//   tick_overrun               : pulse when a tick is dropped
//   rd_idx/rd_data             : registered debug read of a potential
module lif_neuron_array
  import lif_pkg::*;
#(
  parameter int unsigned DATA_WIDTH        = 16,
  parameter int unsigned NUM_NEURONS       = 64,
  parameter int unsigned IDX_W             = $clog2(NUM_NEURONS),
  parameter int          RESET_VAL         = 0,
  parameter int          V_MIN             = 0,
  parameter int unsigned REFRACTORY_PERIOD = 2,
  parameter int unsigned REF_W             = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ev_valid,
  output logic                         ev_ready,
  input  logic [IDX_W-1:0]             ev_idx,
  input  logic signed [DATA_WIDTH-1:0] ev_weight,
  input  logic                         tick,
  input  logic signed [DATA_WIDTH-1:0] cfg_thresh,
  input  logic [DATA_WIDTH-1:0]        cfg_leak,
  output logic                         spk_valid,
  input  logic                         spk_ready,
  output logic [IDX_W-1:0]             spk_idx,
  output logic                         sweep_busy,
  output logic                         tick_overrun,
  input  logic [IDX_W-1:0]             rd_idx,
  output logic signed [DATA_WIDTH-1:0] rd_data
);

  localparam logic signed [DATA_WIDTH-1:0] RST_V    = DATA_WIDTH'(RESET_VAL);
  localparam logic [IDX_W-1:0]             LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  if (REFRACTORY_PERIOD < 1 || REFRACTORY_PERIOD >= (1 << REF_W)) begin : g_bad_ref
    $error("REFRACTORY_PERIOD out of range for REF_W");
  end

  fsm_state_t                   state_q, state_d;
  logic signed [DATA_WIDTH-1:0] v_q [NUM_NEURONS];
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic                         pending_q, pending_d;
  logic signed [DATA_WIDTH-1:0] thresh_q;
  logic [DATA_WIDTH-1:0]        leak_q;
  logic                         spk_valid_q, spk_valid_d;
  logic [IDX_W-1:0]             spk_idx_q, spk_idx_d;
  logic                         overrun_q, overrun_d;
  logic signed [DATA_WIDTH-1:0] rd_data_q;

  logic                         start;
  logic                         ev_acc;
  logic                         ev_in_range;
  logic                         rd_in_range;
  logic signed [DATA_WIDTH-1:0] ev_sum;
  logic signed [DATA_WIDTH-1:0] v_cur;
  logic signed [DATA_WIDTH-1:0] v_upd;
  logic signed [DATA_WIDTH-1:0] v_new;
  logic                         fire_raw;
  logic                         fire;
  logic                         spk_busy;
  logic                         last;
  logic                         stall;
  logic                         commit;

  assign v_cur = v_q[idx_q];

  lif_update_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .RESET_VAL  (RESET_VAL),
    .V_MIN      (V_MIN)
  ) u_update (
    .v_i      (v_cur),
    .thresh_i (thresh_q),
    .leak_i   (leak_q),
    .fire_o   (fire_raw),
    .v_next_o (v_upd)
  );

`ifdef LIF_REFRACTORY_EN
  logic [REF_W-1:0] r_q [NUM_NEURONS];
  logic             refr;

  assign refr   = (r_q[idx_q] != '0);
  assign fire   = fire_raw && !refr;
  assign v_new  = refr ? v_cur : v_upd;
  assign ev_acc = (state_q == IDLE) && ev_valid && ev_in_range && (r_q[ev_idx] == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_NEURONS; i++) r_q[i] <= '0;
    end else if (commit) begin
      if (refr) begin
        r_q[idx_q] <= r_q[idx_q] - 1'b1;
      end else if (fire) begin
        r_q[idx_q] <= REF_W'(REFRACTORY_PERIOD);
      end
    end
  end
`else
  assign fire   = fire_raw;
  assign v_new  = v_upd;
  assign ev_acc = (state_q == IDLE) && ev_valid && ev_in_range;
`endif

  assign ev_in_range = (32'(ev_idx) < NUM_NEURONS);
  assign rd_in_range = (32'(rd_idx) < NUM_NEURONS);
  assign ev_sum      = DATA_WIDTH'(sat_add(lif_word_t'(v_q[ev_idx]), lif_word_t'(ev_weight),
                                           DATA_WIDTH));

  // The last neuron also holds while an older spike is unaccepted, so the sweep
  // never returns to IDLE with a spike from earlier in the sweep still queued.
  assign spk_busy = spk_valid_q && !spk_ready;
  assign last     = (idx_q == LAST_IDX);
  assign stall    = spk_busy && (fire || last);
  assign commit   = (state_q == SWEEP) && !stall;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pending_d   = pending_q;
    overrun_d   = 1'b0;
    spk_valid_d = spk_valid_q && !spk_ready;
    spk_idx_d   = spk_idx_q;
    start       = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick || pending_q) begin
          state_d   = SWEEP;
          idx_d     = '0;
          start     = 1'b1;
          pending_d = tick && pending_q;
        end
      end
      SWEEP: begin
        if (stall) begin
          state_d = STALL;
        end else begin
          if (fire) begin
            spk_valid_d = 1'b1;
            spk_idx_d   = idx_q;
          end
          if (last) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      STALL: begin
        if (spk_ready) begin
          state_d = SWEEP;
        end
      end
      default: state_d = IDLE;
    endcase
    if (tick && (state_q != IDLE)) begin
      if (pending_q) begin
        overrun_d = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      pending_q   <= 1'b0;
      thresh_q    <= '0;
      leak_q      <= '0;
      spk_valid_q <= 1'b0;
      spk_idx_q   <= '0;
      overrun_q   <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pending_q   <= pending_d;
      spk_valid_q <= spk_valid_d;
      spk_idx_q   <= spk_idx_d;
      overrun_q   <= overrun_d;
      if (start) begin
        thresh_q <= cfg_thresh;
        leak_q   <= cfg_leak;
      end
      rd_data_q <= rd_in_range ? v_q[rd_idx] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_NEURONS; i++) v_q[i] <= RST_V;
    end else if (ev_acc) begin
      v_q[ev_idx] <= ev_sum;
    end else if (commit) begin
      v_q[idx_q] <= v_new;
    end
  end

  assign ev_ready     = (state_q == IDLE);
  assign spk_valid    = spk_valid_q;
  assign spk_idx      = spk_idx_q;
  assign sweep_busy   = (state_q != IDLE);
  assign tick_overrun = overrun_q;
  assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed self-checking bench for lif_neuron_array (64 neurons, 16-bit potentials).
module tb_lif_neuron_array;

  localparam int unsigned DW = 16;
  localparam int unsigned N  = 64;
  localparam int unsigned IW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ev_valid = 1'b0;
  logic          ev_ready;
  logic [IW-1:0] ev_idx = '0;
  logic [DW-1:0] ev_weight = '0;
  logic          tick = 1'b0;
  logic [DW-1:0] cfg_thresh = 16'd100;
  logic [DW-1:0] cfg_leak = 16'd1;
  logic          spk_valid;
  logic          spk_ready = 1'b1;
  logic [IW-1:0] spk_idx;
  logic          sweep_busy;
  logic          tick_overrun;
  logic [IW-1:0] rd_idx = '0;
  logic [DW-1:0] rd_data;

  int n_checks = 0;
  int n_fail   = 0;
  int spk_q[$];
  int overrun_cnt = 0;
  int sweep_cnt = 0;
  logic busy_prev = 1'b0;

  lif_neuron_array #(
    .DATA_WIDTH        (DW),
    .NUM_NEURONS       (N),
    .IDX_W             (IW),
    .RESET_VAL         (0),
    .V_MIN             (0),
    .REFRACTORY_PERIOD (2),
    .REF_W             (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_idx       (ev_idx),
    .ev_weight    (ev_weight),
    .tick         (tick),
    .cfg_thresh   (cfg_thresh),
    .cfg_leak     (cfg_leak),
    .spk_valid    (spk_valid),
    .spk_ready    (spk_ready),
    .spk_idx      (spk_idx),
    .sweep_busy   (sweep_busy),
    .tick_overrun (tick_overrun),
    .rd_idx       (rd_idx),
    .rd_data      (rd_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (spk_valid && spk_ready) spk_q.push_back(int'(spk_idx));
      if (tick_overrun) overrun_cnt++;
      if (sweep_busy && !busy_prev) sweep_cnt++;
      busy_prev = sweep_busy;
    end else begin
      busy_prev = 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_ev(input int idx, input logic [DW-1:0] w);
    ev_valid  = 1'b1;
    ev_idx    = IW'(idx);
    ev_weight = w;
    step();
    ev_valid  = 1'b0;
  endtask

  task automatic tick_once();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic rd(input int idx, output logic [DW-1:0] d);
    rd_idx = IW'(idx);
    step();
    d = rd_data;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 400 && sweep_busy; i++) step();
    check_eq(tag, 32'(sweep_busy), 32'd0);
    step();
  endtask

  initial begin
    logic [DW-1:0] d;
    int first_k;
    int ov0, sw0;
    int exp_spk[4];
    int exp_v9[4];

    repeat (3) step();
    rst_n = 1'b1;
    step();

    // 1: reset state
    for (int i = 0; i < int'(N); i++) begin
      rd(i, d);
      check_eq($sformatf("rst_v%0d", i), 32'(d), 32'd0);
    end
    check_eq("rst_spk_valid", 32'(spk_valid), 32'd0);
    check_eq("rst_ev_ready", 32'(ev_ready), 32'd1);
    check_eq("rst_busy", 32'(sweep_busy), 32'd0);

    // 2: integrate to 110, leak 1 -> 109 >= 100 fires neuron 3
    send_ev(3, 16'd60);
    send_ev(3, 16'd50);
    rd(3, d);
    check_eq("t2_v3_int", 32'(d), 32'd110);
    cfg_thresh = 16'd100;
    cfg_leak   = 16'd1;
    spk_q.delete();
    tick_once();
    first_k = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (spk_valid && first_k < 0) first_k = k;
    end
    check_eq("t2_spk_cycle", 32'(first_k), 32'd5);
    wait_idle("t2_idle");
    check_eq("t2_nspk", 32'(spk_q.size()), 32'd1);
    check_eq("t2_spk_idx", 32'(spk_q[0]), 32'd3);
    rd(3, d);
    check_eq("t2_v3_reset", 32'(d), 32'd0);

    // 3: leak 10 per timestep down to the floor
    send_ev(5, 16'd30);
    cfg_leak = 16'd10;
    spk_q.delete();
    for (int t = 0; t < 4; t++) begin
      tick_once();
      wait_idle($sformatf("t3_idle%0d", t));
      rd(5, d);
      check_eq($sformatf("t3_v5_t%0d", t), 32'(d), (t < 2) ? 32'(20 - 10 * t) : 32'd0);
    end
    check_eq("t3_nspk", 32'(spk_q.size()), 32'd0);

    // 4: backpressure with three firing neurons
    send_ev(0, 16'd200);
    send_ev(1, 16'd200);
    send_ev(2, 16'd200);
    spk_q.delete();
    spk_ready = 1'b0;
    tick_once();
    repeat (5) step();
    check_eq("t4_stall_busy", 32'(sweep_busy), 32'd1);
    check_eq("t4_stall_valid", 32'(spk_valid), 32'd1);
    check_eq("t4_stall_idx", 32'(spk_idx), 32'd0);
    spk_ready = 1'b1;
    wait_idle("t4_idle");
    check_eq("t4_nspk", 32'(spk_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("t4_spk%0d", i), 32'(spk_q[i]), 32'(i));
      rd(i, d);
      check_eq($sformatf("t4_v%0d", i), 32'(d), 32'd0);
    end

    // 5: saturation both ways
    send_ev(7, 16'h7FF0);
    rd(7, d);
    check_eq("t5_v7_a", 32'(d), 32'h7FF0);
    send_ev(7, 16'h0100);
    rd(7, d);
    check_eq("t5_v7_satp", 32'(d), 32'h7FFF);
    send_ev(7, 16'h8000);
    rd(7, d);
    check_eq("t5_v7_b", 32'(d), 32'hFFFF);
    send_ev(7, 16'h8000);
    rd(7, d);
    check_eq("t5_v7_satn", 32'(d), 32'h8000);

    // 6: two ticks during a sweep -> one extra sweep, one overrun pulse
    ov0 = overrun_cnt;
    sw0 = sweep_cnt;
    tick_once();
    repeat (3) step();
    tick_once();
    repeat (3) step();
    tick_once();
    repeat (200) step();
    check_eq("t6_idle", 32'(sweep_busy), 32'd0);
    check_eq("t6_overrun", 32'(overrun_cnt - ov0), 32'd1);
    check_eq("t6_sweeps", 32'(sweep_cnt - sw0), 32'd2);
    rd(7, d);
    check_eq("t6_v7_floor", 32'(d), 32'd0);

    // 7: repeated +500 on neuron 9, one timestep each
`ifdef LIF_REFRACTORY_EN
    exp_spk = '{1, 0, 0, 1};
    exp_v9  = '{500, 0, 0, 500};
`else
    exp_spk = '{1, 1, 1, 1};
    exp_v9  = '{500, 500, 500, 500};
`endif
    for (int t = 0; t < 4; t++) begin
      send_ev(9, 16'd500);
      rd(9, d);
      check_eq($sformatf("t7_v9_ev%0d", t), 32'(d), 32'(exp_v9[t]));
      spk_q.delete();
      tick_once();
      wait_idle($sformatf("t7_idle%0d", t));
      check_eq($sformatf("t7_nspk%0d", t), 32'(spk_q.size()), 32'(exp_spk[t]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
